// File: rtl/jk_register_counter.sv
// ----------------------------------------------------------------------------
// jk_register_counter
//
// A WIDTH-bit bank of edge-triggered JK flip-flops that share one clock and one
// asynchronous reset. A mode select reuses the bank as:
//   00 JK    : each bit obeys its own J/K pair (hold / reset / set / toggle)
//   01 COUNT : each bit is a JK cell with J=K=T[i] from a toggle chain,
//              giving an up/down counter
//   10 LOAD  : parallel load of load_val, clears the sticky overflow flag
//   11 HOLD  : no change
//
// Optional feature (compile-time macro JK_SATURATE_EN):
//   defined   -> COUNT mode saturates at all-ones (up) / zero (down)
//   undefined -> COUNT mode wraps modulo 2^WIDTH (default build)
//
// Parameters
//   WIDTH    number of JK cells, legal range 2..32
//   RST_VAL  value forced onto q by rst (zero-extended / truncated to WIDTH)
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous, active-high reset
//   en        in   1      clock enable, 0 holds all state and forces tc low
//   mode      in   2      operating mode (see above)
//   j, k      in   WIDTH  per-bit J/K inputs, used in JK mode only
//   up        in   1      count direction in COUNT mode (1 up, 0 down)
//   load_val  in   WIDTH  value captured in LOAD mode
//   q         out  WIDTH  register state
//   qbar      out  WIDTH  always ~q
//   tc        out  1      terminal count, combinational
//   ovf       out  1      sticky wrap / limit flag, registered
// ----------------------------------------------------------------------------
module jk_register_counter #(
  parameter int WIDTH   = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             up,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q_r;
  logic             ovf_r;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] t_cnt;
  logic [WIDTH-1:0] q_nxt;
  logic             ovf_nxt;
  logic             at_limit;

  assign q    = q_r;
  assign qbar = ~q_r;
  assign ovf  = ovf_r;

  // Ripple toggle chain: bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q_r[i-1];
      t_dn[i] = t_dn[i-1] & ~q_r[i-1];
    end
  end

  assign t_cnt    = up ? t_up : t_dn;
  assign at_limit = up ? (&q_r) : ~(|q_r);
  assign tc       = en & (mode_t'(mode) == MODE_COUNT) & at_limit;

  // Next-state decode. Inputs belonging to other modes are never referenced,
  // so an undriven j/k/load_val/up cannot leak into state.
  always_comb begin
    q_nxt   = q_r;
    ovf_nxt = ovf_r;
    if (en) begin
      case (mode_t'(mode))
        MODE_JK: begin
          // Classic JK characteristic: Q+ = J&~Q | ~K&Q
          q_nxt = (j & ~q_r) | (~k & q_r);
        end
        MODE_COUNT: begin
`ifdef JK_SATURATE_EN
          // At the limit all toggles are suppressed; only the flag moves.
          if (at_limit) begin
            ovf_nxt = 1'b1;
          end else begin
            q_nxt = (t_cnt & ~q_r) | (~t_cnt & q_r);
          end
`else
          // J=K=T cell; at the limit every bit toggles, which is the wrap.
          q_nxt = (t_cnt & ~q_r) | (~t_cnt & q_r);
          if (at_limit) begin
            ovf_nxt = 1'b1;
          end
`endif
        end
        MODE_LOAD: begin
          q_nxt   = load_val;
          ovf_nxt = 1'b0;
        end
        default: begin
          q_nxt   = q_r;
          ovf_nxt = ovf_r;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= RST_Q;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      ovf_r <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_jk_register_counter.sv
// ----------------------------------------------------------------------------
// tb_jk_register_counter
//
// Directed bench for jk_register_counter at WIDTH=4. A second instance with
// RST_VAL=4'hA shares all inputs and is used to observe the reset value.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_jk_register_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         up;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         tc;
  logic         ovf;
  logic [W-1:0] q_a;
  logic [W-1:0] qbar_a;
  logic         tc_a;
  logic         ovf_a;

  int checks = 0;
  int errors = 0;

  jk_register_counter #(.WIDTH(W), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .up(up),
    .load_val(load_val), .q(q), .qbar(qbar), .tc(tc), .ovf(ovf)
  );

  jk_register_counter #(.WIDTH(W), .RST_VAL(4'hA)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .up(up),
    .load_val(load_val), .q(q_a), .qbar(qbar_a), .tc(tc_a), .ovf(ovf_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_q got %h want %h", q, 4'h0); end
    checks++; if (qbar !== 4'hF) begin errors++; $display("FAIL reset_qbar got %h want %h", qbar, 4'hF); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want %b", ovf, 1'b0); end
    checks++; if (q_a !== 4'hA) begin errors++; $display("FAIL reset_q_rstval got %h want %h", q_a, 4'hA); end
    checks++; if (qbar_a !== 4'h5) begin errors++; $display("FAIL reset_qbar_rstval got %h want %h", qbar_a, 4'h5); end
    en   = 1'b1;
    mode = 2'b10;
    load_val = 4'h9;
    tick();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_held_q got %h want %h", q, 4'h0); end
    rst = 1'b0;
    en  = 1'b0;
    mode = 2'b11;
  endtask

  task automatic test_jk();
    en = 1'b1; mode = 2'b00; j = 4'b1100; k = 4'b1010;
    tick();
    // bit3 toggles 0->1, bit2 set, bit1 reset, bit0 holds
    checks++; if (q !== 4'b1100) begin errors++; $display("FAIL jk_edge1 got %b want %b", q, 4'b1100); end
    checks++; if (q_a !== 4'b0100) begin errors++; $display("FAIL jk_edge1_rstval got %b want %b", q_a, 4'b0100); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL jk_tc got %b want %b", tc, 1'b0); end
    en = 1'b0;
    tick();
    checks++; if (q !== 4'b1100) begin errors++; $display("FAIL jk_en_hold got %b want %b", q, 4'b1100); end
    en = 1'b1;
    tick();
    // bit3 toggles back 1->0
    checks++; if (q !== 4'b0100) begin errors++; $display("FAIL jk_edge2 got %b want %b", q, 4'b0100); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL jk_ovf got %b want %b", ovf, 1'b0); end
  endtask

`ifndef JK_SATURATE_EN
  task automatic test_wrap_up();
    en = 1'b1; mode = 2'b10; load_val = 4'hD;
    tick();
    checks++; if (q !== 4'hD) begin errors++; $display("FAIL up_load got %h want %h", q, 4'hD); end
    mode = 2'b01; up = 1'b1; load_val = 4'h3; j = 4'hF; k = 4'hF;
    tick();
    checks++; if (q !== 4'hE) begin errors++; $display("FAIL up_e got %h want %h", q, 4'hE); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_e got %b want %b", tc, 1'b0); end
    tick();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL up_f got %h want %h", q, 4'hF); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL up_tc_f got %b want %b", tc, 1'b1); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL up_ovf_prewrap got %b want %b", ovf, 1'b0); end
    tick();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL up_wrap got %h want %h", q, 4'h0); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL up_ovf_wrap got %b want %b", ovf, 1'b1); end
    repeat (5) tick();
    checks++; if (q !== 4'h5) begin errors++; $display("FAIL up_after5 got %h want %h", q, 4'h5); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL up_ovf_sticky got %b want %b", ovf, 1'b1); end
  endtask

  task automatic test_wrap_down();
    en = 1'b1; mode = 2'b10; load_val = 4'h1;
    tick();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dn_load_ovf got %b want %b", ovf, 1'b0); end
    mode = 2'b01; up = 1'b0;
    tick();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL dn_zero got %h want %h", q, 4'h0); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dn_tc got %b want %b", tc, 1'b1); end
    tick();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL dn_wrap got %h want %h", q, 4'hF); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL dn_ovf got %b want %b", ovf, 1'b1); end
    // at all-ones counting up, en=0 must force tc low
    up = 1'b1; en = 1'b0;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dn_tc_en0 got %b want %b", tc, 1'b0); end
    en = 1'b1; mode = 2'b10; load_val = 4'h5;
    tick();
    checks++; if (q !== 4'h5) begin errors++; $display("FAIL dn_load5 got %h want %h", q, 4'h5); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dn_load_clr got %b want %b", ovf, 1'b0); end
    checks++; if (qbar !== 4'hA) begin errors++; $display("FAIL dn_qbar got %h want %h", qbar, 4'hA); end
  endtask
`else
  task automatic test_saturate();
    en = 1'b1; mode = 2'b10; load_val = 4'hF;
    tick();
    mode = 2'b01; up = 1'b1;
    repeat (4) tick();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL sat_q got %h want %h", q, 4'hF); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL sat_tc got %b want %b", tc, 1'b1); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want %b", ovf, 1'b1); end
    up = 1'b0;
    tick();
    checks++; if (q !== 4'hE) begin errors++; $display("FAIL sat_down got %h want %h", q, 4'hE); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL sat_down_tc got %b want %b", tc, 1'b0); end
    mode = 2'b10; load_val = 4'h0;
    tick();
    mode = 2'b01; up = 1'b0;
    tick();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL sat_zero got %h want %h", q, 4'h0); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_zero_ovf got %b want %b", ovf, 1'b1); end
  endtask
`endif

  task automatic test_reset_mid();
    en = 1'b1; mode = 2'b10; load_val = 4'hF;
    tick();
    mode = 2'b01; up = 1'b1;
    tick();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL mid_ovf_set got %b want %b", ovf, 1'b1); end
    // JK mode reaches 0111 without disturbing the sticky flag
    mode = 2'b00; j = 4'b0111; k = 4'b1000;
    tick();
    checks++; if (q !== 4'b0111) begin errors++; $display("FAIL mid_jk got %b want %b", q, 4'b0111); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL mid_jk_ovf got %b want %b", ovf, 1'b1); end
    mode = 2'b01; up = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL mid_rst_q got %h want %h", q, 4'h0); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got %b want %b", ovf, 1'b0); end
    checks++; if (qbar !== 4'hF) begin errors++; $display("FAIL mid_rst_qbar got %h want %h", qbar, 4'hF); end
    checks++; if (q_a !== 4'hA) begin errors++; $display("FAIL mid_rst_rstval got %h want %h", q_a, 4'hA); end
    tick();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL mid_rst_held got %h want %h", q, 4'h0); end
    rst = 1'b0; mode = 2'b11;
    repeat (3) tick();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL hold_q got %h want %h", q, 4'h0); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL hold_ovf got %b want %b", ovf, 1'b0); end
    checks++; if (q_a !== 4'hA) begin errors++; $display("FAIL hold_rstval got %h want %h", q_a, 4'hA); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b11; j = '0; k = '0; up = 1'b1; load_val = '0;
    test_reset();
    test_jk();
`ifndef JK_SATURATE_EN
    test_wrap_up();
    test_wrap_down();
`else
    test_saturate();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
